// File: rtl/tpu_pkg.sv
// tpu_pkg: shared sizing defaults and feeder state encoding for the TPU west-edge datapath
package tpu_pkg;
  localparam int DATA_SIZE_DEF = 8;
  localparam int MAC_WIDTH_DEF = 8;
  localparam int VCOUNT_W = 16;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feeder_state_e;
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register with synchronous clear
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];
  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) pipe_q[i] <= reset ? '0 : pipe_d[i];
  end
  assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/west_skew_feeder.sv
// west_skew_feeder: staggers activation vectors into a diagonal wavefront for the systolic array
module west_skew_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int MAC_WIDTH = MAC_WIDTH_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_SIZE*MAC_WIDTH-1:0] in_vector,
  input  logic                           in_last,
  output logic [DATA_SIZE*MAC_WIDTH-1:0] data_west,
  output logic [MAC_WIDTH-1:0]           row_valid,
  output logic                           busy,
  output logic                           done,
  output logic [VCOUNT_W-1:0]            vector_count
);
  localparam int DC_W = $clog2(MAC_WIDTH);
  feeder_state_e       state_q, state_d;
  logic [DC_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [VCOUNT_W-1:0] vector_count_q, vector_count_d;
  logic                done_q, done_d;
  logic                beat;
  assign beat = in_valid && in_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      drain_cnt_q    <= '0;
      vector_count_q <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      vector_count_q <= vector_count_d;
      done_q         <= done_d;
    end
  end
  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    vector_count_d = vector_count_q;
    done_d         = 1'b0;
    if (beat) begin
      vector_count_d = (state_q == IDLE) ? VCOUNT_W'(1) : vector_count_q + 1'b1;
      state_d        = in_last ? DRAIN : STREAM;
      drain_cnt_d    = DC_W'(MAC_WIDTH - 1);
    end
    if (state_q == DRAIN) begin
      done_d      = drain_cnt_q == DC_W'(1);
      state_d     = done_d ? IDLE : DRAIN;
      drain_cnt_d = drain_cnt_q - 1'b1;
    end
  end
  always_comb begin
    in_ready = state_q != DRAIN;
    busy     = state_q != IDLE;
  end
  assign done         = done_q;
  assign vector_count = vector_count_q;
  // Non-beat cycles push zero data with valid low so downstream partial sums stay neutral
  for (genvar r = 0; r < MAC_WIDTH; r++) begin : g_row
    logic [DATA_SIZE:0] lane;
    skew_delay_line #(.DEPTH(r + 1), .WIDTH(DATA_SIZE + 1)) u_dl (
      .clock (clock),
      .reset (reset),
      .d     ({beat, {DATA_SIZE{beat}} & in_vector[r*DATA_SIZE +: DATA_SIZE]}),
      .q     (lane)
    );
    assign row_valid[r]                        = lane[DATA_SIZE];
    assign data_west[r*DATA_SIZE +: DATA_SIZE] = lane[DATA_SIZE-1:0];
  end
endmodule

// File: tb/tb_west_skew_feeder.sv
// tb_west_skew_feeder: random and directed streams checked against a cycle-history reference model
module tb_west_skew_feeder;
  localparam int DS = 8;
  localparam int MW = 4;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DS*MW-1:0] in_vector = '0;
  logic          in_ready, busy, done;
  logic [DS*MW-1:0] data_west;
  logic [MW-1:0] row_valid;
  logic [15:0]   vector_count;
  int n_cmp = 0;
  int n_bad = 0;
  logic [DS-1:0] hist_d [8][MW];
  bit            hist_v [8];
  int            cyc = 8;
  int            t_last = 0;
  bit            tl_ok = 0;
  bit            in_stream = 0;
  logic [15:0]   m_count = '0;

  west_skew_feeder #(.DATA_SIZE(DS), .MAC_WIDTH(MW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_vector(in_vector), .in_last(in_last), .data_west(data_west),
    .row_valid(row_valid), .busy(busy), .done(done), .vector_count(vector_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit m_drain();
    return tl_ok && cyc >= t_last && cyc < t_last + MW - 1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      hist_v[i] = 0;
      for (int r = 0; r < MW; r++) hist_d[i][r] = '0;
    end
    in_stream = 0;
    tl_ok = 0;
    m_count = '0;
  endtask

  task automatic check_outputs();
    logic [DS*MW-1:0] edw;
    logic [MW-1:0]    erv;
    for (int r = 0; r < MW; r++) begin
      edw[r*DS +: DS] = hist_d[(cyc - r) & 7][r];
      erv[r]          = hist_v[(cyc - r) & 7];
    end
    chk("data_west", data_west, edw);
    chk("row_valid", row_valid, erv);
    chk("done", done, tl_ok && cyc == t_last + MW - 1);
    chk("in_ready", in_ready, !m_drain());
    chk("busy", busy, in_stream || m_drain());
    chk("vector_count", vector_count, m_count);
  endtask

  task automatic step(input bit v, input logic [DS*MW-1:0] vec, input bit last, input bit rst);
    bit rdy, beat;
    @(negedge clock);
    check_outputs();
    reset = rst;
    in_valid = v;
    in_vector = vec;
    in_last = last;
    rdy = !m_drain();
    cyc++;
    if (rst) clear_model();
    else begin
      beat = v && rdy;
      hist_v[cyc & 7] = beat;
      for (int r = 0; r < MW; r++) hist_d[cyc & 7][r] = beat ? vec[r*DS +: DS] : '0;
      if (beat) begin
        m_count = in_stream ? m_count + 16'd1 : 16'd1;
        if (last) begin
          in_stream = 0;
          tl_ok = 1;
          t_last = cyc;
        end else in_stream = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom, $urandom_range(0, 1), 0);
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clock);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    step(1, 32'h44332211, 1, 0);
    idle(6);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    idle(8);
    step(1, $urandom, 0, 0);
    step(0, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    idle(8);
    step(1, $urandom, 1, 0);
    repeat (MW) step(1, 32'hA5A5A5A5, 0, 0);
    step(1, $urandom, 1, 0);
    idle(8);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    idle(8);
    for (int i = 0; i < 400; i++) begin
      bit rs = $urandom_range(0, 99) == 0;
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 99) < 15, rs);
    end
    step(0, '0, 0, 1);
    idle(8);
    for (int i = 0; i < 65536; i++) step(1, $urandom, 0, 0);
    step(1, $urandom, 1, 0);
    idle(6);
    @(negedge clock);
    chk("wrap_count", vector_count, 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
